// File: rtl/if_id_pipe.sv
// IF->ID pipeline buffer: small FIFO carrying {pc4, instr} from fetch to decode
// over a valid/ready handshake, with branch flush and a saturating stall counter.
module if_id_pipe #(
    parameter int unsigned DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int unsigned STALL_W   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_pc4,
    input  logic [31:0]        in_instr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_pc4,
    output logic [31:0]        out_instr,
    output logic [STALL_W-1:0] stall_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [63:0]        mem [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic               push;
    logic               pop;

    // Handshake flags come only from the occupancy register.
    assign in_ready  = (count < DEPTH_C);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        out_pc4   = '0;
        out_instr = NOP_INSTR;
        if (out_valid) begin
            out_pc4   = mem[rd_ptr][63:32];
            out_instr = mem[rd_ptr][31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= {in_pc4, in_instr};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

endmodule

// File: tb/tb_if_id_pipe.sv
// Scoreboard bench for if_id_pipe: directed scenarios followed by random traffic.
module tb_if_id_pipe;

    localparam int DEPTH = 2;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_pc4, in_instr, out_pc4, out_instr;
    logic [15:0] stall_cnt;
    logic        sat_in_ready, sat_out_valid;
    logic [31:0] sat_out_pc4, sat_out_instr;
    logic [3:0]  sat_stall;

    always #5 clk = ~clk;

    if_id_pipe #(.DEPTH(DEPTH), .NOP_INSTR(NOP), .STALL_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc4(in_pc4), .in_instr(in_instr), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc4(out_pc4),
        .out_instr(out_instr), .stall_cnt(stall_cnt)
    );

    // Narrow-counter copy sharing all inputs, used to observe saturation.
    if_id_pipe #(.DEPTH(DEPTH), .NOP_INSTR(NOP), .STALL_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready),
        .in_pc4(in_pc4), .in_instr(in_instr), .flush(flush),
        .out_valid(sat_out_valid), .out_ready(out_ready), .out_pc4(sat_out_pc4),
        .out_instr(sat_out_instr), .stall_cnt(sat_stall)
    );

    int          compared   = 0;
    int          mismatched = 0;
    logic [63:0] exp_q[$];
    int unsigned stall_exp  = 0;
    int          occ_at_neg = 0;
    bit          chk_en     = 1'b0;
    bit          pend_valid = 1'b0;
    bit          pend_flush = 1'b0;
    logic [63:0] pend_data  = '0;
    logic [63:0] head;
    int          sz;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int unsigned sat15(input int unsigned v);
        return (v > 15) ? 15 : v;
    endfunction

    // Monitor: compare presented state against the model, then retire the
    // head when decode takes it (or drop everything on flush).
    always @(negedge clk) begin
        if (chk_en) begin
            sz   = exp_q.size();
            head = (sz != 0) ? exp_q[0] : {32'h0, NOP};
            check("out_valid", 64'(out_valid), 64'(sz != 0));
            check("in_ready", 64'(in_ready), 64'(sz < DEPTH));
            check("out_data", {out_pc4, out_instr}, head);
            check("stall_cnt", 64'(stall_cnt), 64'(stall_exp));
            check("stall_sat", 64'(sat_stall), 64'(sat15(stall_exp)));
            check("sat_data", {sat_out_pc4, sat_out_instr}, head);
            occ_at_neg = sz;
            if (sz != 0 && !out_ready && !flush && stall_exp < 65535) stall_exp++;
            if (flush) exp_q.delete();
            else if (sz != 0 && out_ready) void'(exp_q.pop_front());
        end
    end

    // Drive one cycle of stimulus; the word offered last cycle enters the
    // expected queue if the buffer had room and no flush killed it.
    task automatic cycle(input bit v, input logic [31:0] pc, input logic [31:0] ins,
                         input bit ordy, input bit fl);
        @(posedge clk);
        #1;
        if (pend_valid && !pend_flush && occ_at_neg < DEPTH) exp_q.push_back(pend_data);
        in_valid   = v;
        in_pc4     = pc;
        in_instr   = ins;
        out_ready  = ordy;
        flush      = fl;
        pend_valid = v;
        pend_flush = fl;
        pend_data  = {pc, ins};
    endtask

    task automatic idle(input int n, input bit ordy);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, ordy, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        chk_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_data", {out_pc4, out_instr}, {32'h0, NOP});
        check("rst_stall", 64'(stall_cnt), 64'(0));
        check("rst_stall_sat", 64'(sat_stall), 64'(0));
        exp_q.delete();
        stall_exp  = 0;
        pend_valid = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        flush      = 1'b0;
        @(negedge clk);
        #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        in_pc4 = '0; in_instr = '0;

        do_reset();
        cycle(1'b1, 32'd4,  32'hAAAA_0001, 1'b1, 1'b0);
        cycle(1'b1, 32'd8,  32'hBBBB_0002, 1'b1, 1'b0);
        cycle(1'b1, 32'd12, 32'hCCCC_0003, 1'b1, 1'b0);
        idle(3, 1'b1);

        do_reset();
        cycle(1'b1, 32'd4,  32'hAAAA_0001, 1'b0, 1'b0);
        cycle(1'b1, 32'd8,  32'hBBBB_0002, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'd12, 32'hCCCC_0003, 1'b0, 1'b0);
        cycle(1'b1, 32'd12, 32'hCCCC_0003, 1'b1, 1'b0);
        cycle(1'b1, 32'd12, 32'hCCCC_0003, 1'b1, 1'b0);
        idle(4, 1'b1);

        do_reset();
        cycle(1'b1, 32'd4,  32'hAAAA_0001, 1'b0, 1'b0);
        cycle(1'b1, 32'd8,  32'hBBBB_0002, 1'b0, 1'b0);
        cycle(1'b1, 32'd16, 32'hDDDD_0004, 1'b1, 1'b1);
        cycle(1'b1, 32'd40, 32'hEEEE_0005, 1'b0, 1'b0);
        idle(3, 1'b1);

        do_reset();
        cycle(1'b1, 32'd100, 32'h1000_0000, 1'b1, 1'b0);
        for (int i = 1; i <= 6; i++)
            cycle(1'b1, 32'(100 + 4 * i), 32'h1000_0000 + 32'(i), 1'b1, 1'b0);
        idle(3, 1'b1);

        do_reset();
        cycle(1'b1, 32'd200, 32'h2222_2222, 1'b0, 1'b0);
        idle(20, 1'b0);
        idle(3, 1'b1);

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            cycle(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
        end
        idle(4, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
